pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencing with redirect/squash control, a saturating
// redirect counter and a registered register-file write port that merges
// writeback writes with jal link writes through a one-entry link buffer.
// Optional macro: BRANCH_DELAY_SLOT_EN (when defined, no squash after redirect;
// the instruction after a branch executes as a delay slot).
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        link_valid,
   input  logic [31:0] link_data,
   input  logic        wb_we,
   input  logic [4:0]  wb_sel,
   input  logic [31:0] wb_data,
   output logic [31:0] pc,
   output logic        fetch_valid,
   output logic        squash,
   output logic        rf_we,
   output logic [4:0]  rf_sel,
   output logic [31:0] rf_data,
   output logic        link_stall,
   output logic [15:0] redirect_count
);

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DELAY_SLOT = 1'b1;
`else
   localparam bit DELAY_SLOT = 1'b0;
`endif

   localparam logic [4:0] LINK_REG = 5'd31;

   typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] redirect_count_q, redirect_count_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_sel_q, rf_sel_d;
   logic [31:0] rf_data_q, rf_data_d;
   logic        link_buf_full_q, link_buf_full_d;
   logic [31:0] link_buf_data_q, link_buf_data_d;
   logic        link_stall_c;
   logic        fetch_live;
   logic        wb_hit;

   assign fetch_live = (state_q != BOOT) && !stall;
   assign wb_hit     = wb_we && (wb_sel != 5'd0);

   // FSM next state: a redirect opens a one-cycle squash window unless delay slots are enabled
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (redirect_valid && !DELAY_SLOT) state_d = SQUASH;
         SQUASH:  state_d = redirect_valid ? SQUASH : RUN;
         default: state_d = BOOT;
      endcase
   end

   // PC next value and saturating redirect counter
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid)  pc_d = {redirect_pc[31:2], 2'b00};
      else if (fetch_live) pc_d = pc_q + 32'd4;
      redirect_count_d = redirect_count_q;
      if (redirect_valid && (redirect_count_q != '1))
         redirect_count_d = redirect_count_q + 16'd1;
   end

   // Write-port arbitration: WB first, then the buffered link, then a fresh link request
   always_comb begin
      rf_we_d         = 1'b0;
      rf_sel_d        = '0;
      rf_data_d       = '0;
      link_buf_full_d = link_buf_full_q;
      link_buf_data_d = link_buf_data_q;
      link_stall_c    = 1'b0;
      if (wb_hit) begin
         rf_we_d   = 1'b1;
         rf_sel_d  = wb_sel;
         rf_data_d = wb_data;
         // younger WB write to r31 makes the buffered link value stale
         if (wb_sel == LINK_REG) link_buf_full_d = 1'b0;
         if (link_valid) begin
            if (!link_buf_full_q) begin
               link_buf_full_d = 1'b1;
               link_buf_data_d = link_data;
            end else begin
               link_stall_c = 1'b1;
            end
         end
      end else if (link_buf_full_q) begin
         rf_we_d         = 1'b1;
         rf_sel_d        = LINK_REG;
         rf_data_d       = link_buf_data_q;
         link_buf_full_d = link_valid;
         if (link_valid) link_buf_data_d = link_data;
      end else if (link_valid) begin
         rf_we_d   = 1'b1;
         rf_sel_d  = LINK_REG;
         rf_data_d = link_data;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= BOOT;
         pc_q             <= RESET_PC;
         redirect_count_q <= '0;
         rf_we_q          <= 1'b0;
         rf_sel_q         <= '0;
         rf_data_q        <= '0;
         link_buf_full_q  <= 1'b0;
         link_buf_data_q  <= '0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         redirect_count_q <= redirect_count_d;
         rf_we_q          <= rf_we_d;
         rf_sel_q         <= rf_sel_d;
         rf_data_q        <= rf_data_d;
         link_buf_full_q  <= link_buf_full_d;
         link_buf_data_q  <= link_buf_data_d;
      end
   end

   assign pc             = pc_q;
   assign fetch_valid    = fetch_live;
   assign squash         = (state_q == SQUASH);
   assign rf_we          = rf_we_q;
   assign rf_sel         = rf_sel_q;
   assign rf_data        = rf_data_q;
   assign link_stall     = link_stall_c && !reset;
   assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the fetch/writeback rules.
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        link_valid;
   logic [31:0] link_data;
   logic        wb_we;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        squash;
   logic        rf_we;
   logic [4:0]  rf_sel;
   logic [31:0] rf_data;
   logic        link_stall;
   logic [15:0] redirect_count;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef BRANCH_DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .link_valid(link_valid), .link_data(link_data),
      .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
      .pc(pc), .fetch_valid(fetch_valid), .squash(squash),
      .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data),
      .link_stall(link_stall), .redirect_count(redirect_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc;
   bit          m_live;      // at least one cycle has passed since reset
   bit          m_squash;
   int          m_cnt;
   bit          m_rf_we;
   logic [4:0]  m_rf_sel;
   logic [31:0] m_rf_data;
   logic [31:0] m_buf[$];

   function automatic bit exp_link_stall();
      return !reset && link_valid && (m_buf.size() != 0) && wb_we && (wb_sel != 5'd0);
   endfunction

   // advance one clock, moving the model forward with the inputs seen before the edge
   task automatic tick();
      logic [31:0] n_pc, n_data;
      bit          n_sq, n_we;
      int          n_cnt;
      logic [4:0]  n_sel;
      logic [31:0] nb[$];
      bit          was_full;
      nb = m_buf;
      if (reset) begin
         n_pc = 32'h0; n_sq = 0; n_cnt = 0; n_we = 0; n_sel = 0; n_data = 0;
         nb.delete();
      end else begin
         if (redirect_valid)          n_pc = redirect_pc & 32'hFFFF_FFFC;
         else if (m_live && !stall)   n_pc = m_pc + 32'd4;
         else                         n_pc = m_pc;
         n_sq  = redirect_valid && m_live && !DS;
         n_cnt = (redirect_valid && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
         n_we = 0; n_sel = 0; n_data = 0;
         was_full = (nb.size() != 0);
         if (wb_we && wb_sel != 0) begin
            n_we = 1; n_sel = wb_sel; n_data = wb_data;
            if (wb_sel == 5'd31) nb.delete();
            if (link_valid && !was_full) nb.push_back(link_data);
         end else if (was_full) begin
            n_we = 1; n_sel = 5'd31; n_data = nb.pop_front();
            if (link_valid) nb.push_back(link_data);
         end else if (link_valid) begin
            n_we = 1; n_sel = 5'd31; n_data = link_data;
         end
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_squash = n_sq; m_cnt = n_cnt;
      m_rf_we = n_we; m_rf_sel = n_sel; m_rf_data = n_data;
      m_buf = nb;
      m_live = !reset;
   endtask

   task automatic idle();
      stall = 0; redirect_valid = 0; redirect_pc = 0;
      link_valid = 0; link_data = 0; wb_we = 0; wb_sel = 0; wb_data = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1; stall = 0; redirect_valid = 1; redirect_pc = 32'h1234_5678;
      link_valid = 1; link_data = 32'h55; wb_we = 1; wb_sel = 5'd3; wb_data = 32'h77;
      tick(); tick();
      n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid); else n_pass++;
      n_checks++; if (squash !== 1'b0) $display("FAIL reset_squash got=%b exp=0", squash); else n_pass++;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== 38'h0) $display("FAIL reset_rf got=%b/%0d/%h exp=0/0/0", rf_we, rf_sel, rf_data); else n_pass++;
      n_checks++; if (link_stall !== 1'b0) $display("FAIL reset_link_stall got=%b exp=0", link_stall); else n_pass++;
      n_checks++; if (redirect_count !== 16'h0) $display("FAIL reset_count got=%h exp=0", redirect_count); else n_pass++;
   endtask

   task automatic test_boot_sequence();
      logic [31:0] exp_pc[4] = '{32'h0, 32'h0, 32'h4, 32'h8};
      bit          exp_fv[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      idle(); reset = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (pc !== exp_pc[i]) $display("FAIL boot_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); else n_pass++;
         n_checks++; if (fetch_valid !== exp_fv[i]) $display("FAIL boot_fv[%0d] got=%b exp=%b", i, fetch_valid, exp_fv[i]); else n_pass++;
         if (i < 3) tick();
      end
   endtask

   task automatic test_redirect();
      stall = 1; redirect_valid = 1; redirect_pc = 32'h0000_1003;
      #1;
      n_checks++; if (squash !== 1'b0) $display("FAIL redir_pre_squash got=%b exp=0", squash); else n_pass++;
      tick();
      redirect_valid = 0; #1;
      n_checks++; if (pc !== 32'h0000_1000) $display("FAIL redir_pc got=%h exp=%h", pc, 32'h1000); else n_pass++;
      n_checks++; if (squash !== !DS) $display("FAIL redir_squash got=%b exp=%b", squash, !DS); else n_pass++;
      n_checks++; if (redirect_count !== 16'd1) $display("FAIL redir_count got=%0d exp=1", redirect_count); else n_pass++;
      n_checks++; if (fetch_valid !== 1'b0) $display("FAIL redir_fv_stall got=%b exp=0", fetch_valid); else n_pass++;
      tick(); #1;
      n_checks++; if (squash !== 1'b0) $display("FAIL redir_squash_once got=%b exp=0", squash); else n_pass++;
      n_checks++; if (pc !== 32'h0000_1000) $display("FAIL redir_stall_hold got=%h exp=%h", pc, 32'h1000); else n_pass++;
      stall = 0;
   endtask

   task automatic test_wrap();
      stall = 0; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 0; #1;
      n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_load got=%h exp=fffffffc", pc); else n_pass++;
      tick(); #1;
      n_checks++; if (pc !== 32'h0) $display("FAIL wrap_pc got=%h exp=00000000", pc); else n_pass++;
   endtask

   task automatic test_link();
      idle();
      wb_we = 1; wb_sel = 5'd5; wb_data = 32'hA5; link_valid = 1; link_data = 32'h44; #1;
      n_checks++; if (link_stall !== 1'b0) $display("FAIL link_first_stall got=%b exp=0", link_stall); else n_pass++;
      tick();
      idle(); #1;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 5'd5, 32'hA5}) $display("FAIL link_wb_r5 got=%b/%0d/%h exp=1/5/a5", rf_we, rf_sel, rf_data); else n_pass++;
      tick(); #1;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 5'd31, 32'h44}) $display("FAIL link_r31 got=%b/%0d/%h exp=1/31/44", rf_we, rf_sel, rf_data); else n_pass++;
      tick();
      // refill the buffer, then collide a second request with a busy port
      wb_we = 1; wb_sel = 5'd5; wb_data = 32'hA5; link_valid = 1; link_data = 32'h44;
      tick();
      wb_we = 1; wb_sel = 5'd6; wb_data = 32'h66; link_valid = 1; link_data = 32'h55; #1;
      n_checks++; if (link_stall !== 1'b1) $display("FAIL link_stall_busy got=%b exp=1", link_stall); else n_pass++;
      tick();
      wb_we = 0; #1;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 5'd6, 32'h66}) $display("FAIL link_wb_r6 got=%b/%0d/%h exp=1/6/66", rf_we, rf_sel, rf_data); else n_pass++;
      n_checks++; if (link_stall !== 1'b0) $display("FAIL link_stall_drain got=%b exp=0", link_stall); else n_pass++;
      tick();
      link_valid = 0; #1;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 5'd31, 32'h44}) $display("FAIL link_drain_44 got=%b/%0d/%h exp=1/31/44", rf_we, rf_sel, rf_data); else n_pass++;
      tick(); #1;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 5'd31, 32'h55}) $display("FAIL link_drain_55 got=%b/%0d/%h exp=1/31/55", rf_we, rf_sel, rf_data); else n_pass++;
      tick();
      wb_we = 1; wb_sel = 5'd0; wb_data = 32'hDEAD; link_valid = 1; link_data = 32'h77; #1;
      n_checks++; if (rf_we !== 1'b0) $display("FAIL link_idle got=%b exp=0", rf_we); else n_pass++;
      tick();
      idle(); #1;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 5'd31, 32'h77}) $display("FAIL link_sel0_free got=%b/%0d/%h exp=1/31/77", rf_we, rf_sel, rf_data); else n_pass++;
      tick();
   endtask

   task automatic test_drop();
      idle();
      wb_we = 1; wb_sel = 5'd5; wb_data = 32'hA5; link_valid = 1; link_data = 32'h44;
      tick();
      idle(); wb_we = 1; wb_sel = 5'd31; wb_data = 32'h99;
      tick();
      idle(); #1;
      n_checks++; if ({rf_we, rf_sel, rf_data} !== {1'b1, 5'd31, 32'h99}) $display("FAIL drop_r31_99 got=%b/%0d/%h exp=1/31/99", rf_we, rf_sel, rf_data); else n_pass++;
      tick(); #1;
      n_checks++; if (rf_we !== 1'b0) $display("FAIL drop_no_44 got=%b/%0d/%h exp=0", rf_we, rf_sel, rf_data); else n_pass++;
      tick(); #1;
      n_checks++; if (rf_we !== 1'b0) $display("FAIL drop_empty got=%b/%0d/%h exp=0", rf_we, rf_sel, rf_data); else n_pass++;
   endtask

   task automatic test_random();
      bit hold = 0;
      idle(); reset = 1; tick(); reset = 0;
      for (int i = 0; i < 600; i++) begin
         reset          = ($urandom_range(0, 79) == 0);
         stall          = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 4) == 0);
         redirect_pc    = $urandom();
         if (!hold) begin
            link_valid = ($urandom_range(0, 2) == 0);
            link_data  = $urandom();
         end
         wb_we   = $urandom_range(0, 1);
         wb_sel  = ($urandom_range(0, 3) == 0) ? 5'd31 : ($urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 30)));
         wb_data = $urandom();
         #1;
         n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, m_pc); else n_pass++;
         n_checks++; if (fetch_valid !== (m_live && !stall)) $display("FAIL rnd_fv[%0d] got=%b exp=%b", i, fetch_valid, m_live && !stall); else n_pass++;
         n_checks++; if (squash !== m_squash) $display("FAIL rnd_squash[%0d] got=%b exp=%b", i, squash, m_squash); else n_pass++;
         n_checks++; if (link_stall !== exp_link_stall()) $display("FAIL rnd_link_stall[%0d] got=%b exp=%b", i, link_stall, exp_link_stall()); else n_pass++;
         n_checks++; if (rf_we !== m_rf_we) $display("FAIL rnd_rf_we[%0d] got=%b exp=%b", i, rf_we, m_rf_we); else n_pass++;
         if (m_rf_we) begin
            n_checks++; if ({rf_sel, rf_data} !== {m_rf_sel, m_rf_data}) $display("FAIL rnd_rf[%0d] got=%0d/%h exp=%0d/%h", i, rf_sel, rf_data, m_rf_sel, m_rf_data); else n_pass++;
         end
         n_checks++; if (redirect_count !== 16'(m_cnt)) $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, redirect_count, m_cnt); else n_pass++;
         hold = exp_link_stall();
         tick();
      end
      reset = 0;
   endtask

   task automatic test_saturate();
      idle(); reset = 1; tick(); reset = 0;
      redirect_valid = 1;
      for (int i = 0; i < 65540; i++) begin
         redirect_pc = $urandom();
         stall       = $urandom_range(0, 1);
         tick();
         if (i == 65533) begin
            n_checks++; if (redirect_count !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", redirect_count); else n_pass++;
         end
      end
      #1;
      n_checks++; if (redirect_count !== 16'hFFFF) $display("FAIL sat_count got=%h exp=ffff", redirect_count); else n_pass++;
      n_checks++; if (redirect_count !== 16'(m_cnt)) $display("FAIL sat_model got=%h exp=%h", redirect_count, 16'(m_cnt)); else n_pass++;
      n_checks++; if (squash !== !DS) $display("FAIL sat_squash got=%b exp=%b", squash, !DS); else n_pass++;
      reset = 1; redirect_valid = 1; tick(); #1;
      n_checks++; if (redirect_count !== 16'h0) $display("FAIL sat_reset got=%h exp=0", redirect_count); else n_pass++;
      n_checks++; if (squash !== 1'b0) $display("FAIL sat_reset_squash got=%b exp=0", squash); else n_pass++;
      reset = 0; idle();
   endtask

   initial begin
      m_pc = 0; m_live = 0; m_squash = 0; m_cnt = 0;
      m_rf_we = 0; m_rf_sel = 0; m_rf_data = 0;
      idle(); reset = 1;
      test_reset();
      test_boot_sequence();
      test_redirect();
      test_wrap();
      test_link();
      test_drop();
      test_random();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
